vga_pattern_sequencer: RTL and testbench

Frame-synchronous controller for the VGA pixel datapath, sitting between the 480p timing core and the output register stage of the VGA top. It owns the test-pattern selection. It either auto-advances through four built-in patterns every `FRAMES_PER_PATTERN` frames or switches on a 4-phase request/acknowledge handshake. Every switch takes effect only at a frame boundary, so no frame is ever torn. It renders the selected pattern with one cycle of registered latency.

---
 rtl/vga_pattern_sequencer.sv | 143 ++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer for the VGA pixel path: picks one of four patterns,
// switches only at frame boundaries, and renders it with one registered cycle.
module vga_pattern_sequencer #(
  parameter int H_ACTIVE           = 640,
  parameter int V_ACTIVE           = 480,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic       i_VGA_CLK,
  input  logic       i_rst_n,
  input  logic       i_de,
  input  logic [9:0] i_Sx,
  input  logic [9:0] i_Sy,
  input  logic       i_auto,
  input  logic       i_req,
  input  logic [1:0] i_req_sel,
  output logic       o_ack,
  output logic [1:0] o_pattern,
  output logic [7:0] o_R,
  output logic [7:0] o_G,
  output logic [7:0] o_B,
  output logic       o_de
);

  localparam int CNT_W = $clog2(FRAMES_PER_PATTERN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         pattern_q, pattern_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               fb;
  logic [7:0]         x, y;
  logic [7:0]         r_d, g_d, b_d;

  assign fb = i_de && (i_Sx == 10'(H_ACTIVE - 1)) && (i_Sy == 10'(V_ACTIVE - 1));
  assign x  = i_Sx[7:0];
  assign y  = i_Sy[7:0];

  assign o_ack     = (state_q == ACK);
  assign o_pattern = pattern_q;

  always_ff @(posedge i_VGA_CLK) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      pattern_q   <= 2'd0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pattern_q   <= pattern_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // A pending manual commit owns the frame boundary; auto advance is frozen in PEND.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pattern_d   = pattern_q;
    frame_cnt_d = frame_cnt_q;

    if (!i_auto) begin
      frame_cnt_d = '0;
    end else if (state_q != PEND && fb) begin
      if (frame_cnt_q == CNT_W'(FRAMES_PER_PATTERN - 1)) begin
        pattern_d   = pattern_q + 2'd1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (i_req) begin
          sel_d   = i_req_sel;
          state_d = PEND;
        end
      end
      PEND: begin
        if (fb) begin
          pattern_d   = sel_q;
          frame_cnt_d = '0;
          state_d     = ACK;
        end
      end
      ACK: begin
        if (!i_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    case (pattern_q)
      2'd0: begin
        if (i_Sx < 10'd100 && i_Sy < 10'd100) begin
          r_d = 8'hFF; g_d = 8'h88; b_d = 8'h00;
        end else begin
          r_d = 8'h00; g_d = 8'h88; b_d = 8'hFF;
        end
      end
      2'd1: begin
        r_d = y; g_d = ~y; b_d = x;
      end
      2'd2: begin
        r_d = y; g_d = x ^ y; b_d = x;
      end
      default: begin
        if (i_Sy[0])      r_d = x;
        else if (i_Sy[1]) g_d = x;
        else if (i_Sy[2]) b_d = x;
        else if (i_Sy[3]) begin r_d = x; g_d = x; end
        else if (i_Sy[4]) begin g_d = x; b_d = x; end
        else if (i_Sy[5]) begin r_d = x; b_d = x; end
      end
    endcase
  end

  always_ff @(posedge i_VGA_CLK) begin
    if (!i_rst_n) begin
      o_R  <= 8'h00;
      o_G  <= 8'h00;
      o_B  <= 8'h00;
      o_de <= 1'b0;
    end else begin
      o_de <= i_de;
      o_R  <= i_de ? r_d : 8'h00;
      o_G  <= i_de ? g_d : 8'h00;
      o_B  <= i_de ? b_d : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed bench for vga_pattern_sequencer; two instances (2 and 1 frames per
// pattern) share one stimulus stream on a shrunken 8x4 frame.
module tb_vga_pattern_sequencer;

  localparam int H = 8;
  localparam int V = 4;

  logic       i_VGA_CLK = 1'b0;
  logic       i_rst_n   = 1'b0;
  logic       i_de      = 1'b0;
  logic [9:0] i_Sx      = '0;
  logic [9:0] i_Sy      = '0;
  logic       i_auto    = 1'b0;
  logic       i_req     = 1'b0;
  logic [1:0] i_req_sel = 2'd0;

  logic       ack_a, de_a, ack_b, de_b;
  logic [1:0] pat_a, pat_b;
  logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int errors = 0;
  int checks = 0;

  always #5 i_VGA_CLK = ~i_VGA_CLK;

  vga_pattern_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAMES_PER_PATTERN(2)) dut_a (
    .i_VGA_CLK(i_VGA_CLK), .i_rst_n(i_rst_n), .i_de(i_de), .i_Sx(i_Sx), .i_Sy(i_Sy),
    .i_auto(i_auto), .i_req(i_req), .i_req_sel(i_req_sel), .o_ack(ack_a),
    .o_pattern(pat_a), .o_R(r_a), .o_G(g_a), .o_B(b_a), .o_de(de_a)
  );

  vga_pattern_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAMES_PER_PATTERN(1)) dut_b (
    .i_VGA_CLK(i_VGA_CLK), .i_rst_n(i_rst_n), .i_de(i_de), .i_Sx(i_Sx), .i_Sy(i_Sy),
    .i_auto(i_auto), .i_req(i_req), .i_req_sel(i_req_sel), .o_ack(ack_b),
    .o_pattern(pat_b), .o_R(r_b), .o_G(g_b), .o_B(b_b), .o_de(de_b)
  );

  // Drive one pixel, let the next rising edge sample it, then settle.
  task automatic applyStimulus(input logic de, input logic [9:0] sx, input logic [9:0] sy);
    i_de = de;
    i_Sx = sx;
    i_Sy = sy;
    @(posedge i_VGA_CLK);
    #1;
  endtask

  task automatic midFrame();
    applyStimulus(1'b1, 10'd2, 10'd1);
    applyStimulus(1'b1, 10'd3, 10'd1);
  endtask

  task automatic lastPixel();
    applyStimulus(1'b1, 10'(H - 1), 10'(V - 1));
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      i_auto    = 1'($urandom);
      i_req     = 1'($urandom);
      i_req_sel = 2'($urandom);
      applyStimulus(1'b1, 10'($urandom), 10'($urandom));
    end
    checkOutput("rst_R", r_a, 8'h00);
    checkOutput("rst_G", g_a, 8'h00);
    checkOutput("rst_B", b_a, 8'h00);
    checkOutput("rst_de", {7'd0, de_a}, 8'h00);
    checkOutput("rst_ack", {7'd0, ack_a}, 8'h00);
    checkOutput("rst_pat", {6'd0, pat_a}, 8'h00);
    checkOutput("rst_pat_b", {6'd0, pat_b}, 8'h00);

    i_rst_n = 1'b1;
    i_auto  = 1'b0;
    i_req   = 1'b0;
    i_req_sel = 2'd0;
    applyStimulus(1'b1, 10'd10, 10'd20);
    checkOutput("post_rst_pat", {6'd0, pat_a}, 8'h00);
    checkOutput("sq_in_R", r_a, 8'hFF);
    checkOutput("sq_in_G", g_a, 8'h88);
    checkOutput("sq_in_B", b_a, 8'h00);
    applyStimulus(1'b1, 10'd100, 10'd20);
    checkOutput("sq_out_R", r_a, 8'h00);
    checkOutput("sq_out_B", b_a, 8'hFF);
    applyStimulus(1'b0, 10'd10, 10'd20);
    checkOutput("blank_R", r_a, 8'h00);
    checkOutput("blank_de", {7'd0, de_a}, 8'h00);

    // Auto advance: 2 frames per pattern on dut_a, every frame on dut_b
    i_auto = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      midFrame();
      checkOutput($sformatf("auto_pre%0d", k), {6'd0, pat_a}, 8'(((k - 1) / 2) % 4));
      lastPixel();
      checkOutput($sformatf("auto_post%0d", k), {6'd0, pat_a}, 8'((k / 2) % 4));
      checkOutput($sformatf("auto_b%0d", k), {6'd0, pat_b}, 8'(k % 4));
    end
    applyStimulus(1'b0, 10'd0, 10'd0);

    // Manual switch to pattern 2 with auto off
    i_auto    = 1'b0;
    i_req_sel = 2'd2;
    i_req     = 1'b1;
    midFrame();
    checkOutput("man_hold_pat", {6'd0, pat_a}, 8'h00);
    checkOutput("man_hold_ack", {7'd0, ack_a}, 8'h00);
    i_req_sel = 2'd1;
    midFrame();
    checkOutput("man_pend_pat", {6'd0, pat_a}, 8'h00);
    lastPixel();
    checkOutput("man_commit_pat", {6'd0, pat_a}, 8'h02);
    checkOutput("man_commit_ack", {7'd0, ack_a}, 8'h01);
    checkOutput("man_fb_oldpat_R", r_a, 8'hFF);
    checkOutput("man_commit_pat_b", {6'd0, pat_b}, 8'h02);
    applyStimulus(1'b1, 10'h0F3, 10'h015);
    checkOutput("man_ack_held", {7'd0, ack_a}, 8'h01);
    checkOutput("xor_R", r_a, 8'h15);
    checkOutput("xor_G", g_a, 8'hE6);
    checkOutput("xor_B", b_a, 8'hF3);
    i_req = 1'b0;
    applyStimulus(1'b0, 10'd0, 10'd0);
    checkOutput("man_ack_drop", {7'd0, ack_a}, 8'h00);

    // Collision: dut_b at pattern 1 with a pending request for 0
    i_auto = 1'b1;
    for (int k = 0; k < 3; k++) begin
      midFrame();
      lastPixel();
    end
    checkOutput("col_setup_b", {6'd0, pat_b}, 8'h01);
    checkOutput("col_setup_a", {6'd0, pat_a}, 8'h03);
    i_req_sel = 2'd0;
    i_req     = 1'b1;
    midFrame();
    lastPixel();
    checkOutput("col_commit_b", {6'd0, pat_b}, 8'h00);
    checkOutput("col_commit_a", {6'd0, pat_a}, 8'h00);
    checkOutput("col_ack_b", {7'd0, ack_b}, 8'h01);
    i_req = 1'b0;
    midFrame();
    lastPixel();
    checkOutput("col_next_b", {6'd0, pat_b}, 8'h01);
    checkOutput("col_next_a", {6'd0, pat_a}, 8'h00);
    applyStimulus(1'b1, 10'h012, 10'h034);
    checkOutput("grad_R", r_b, 8'h34);
    checkOutput("grad_G", g_b, 8'hCB);
    checkOutput("grad_B", b_b, 8'h12);

    // Reset while a request is pending
    i_auto    = 1'b0;
    i_req_sel = 2'd3;
    i_req     = 1'b1;
    midFrame();
    i_rst_n = 1'b0;
    applyStimulus(1'b1, 10'd4, 10'd1);
    i_rst_n = 1'b1;
    i_req   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      midFrame();
      checkOutput($sformatf("rp_ack_mid%0d", k), {7'd0, ack_a}, 8'h00);
      lastPixel();
      checkOutput($sformatf("rp_ack_fb%0d", k), {7'd0, ack_a}, 8'h00);
      checkOutput($sformatf("rp_pat%0d", k), {6'd0, pat_a}, 8'h00);
      checkOutput($sformatf("rp_pat_b%0d", k), {6'd0, pat_b}, 8'h00);
    end

    // Select pattern 3 and check band pixels
    i_req_sel = 2'd3;
    i_req     = 1'b1;
    midFrame();
    lastPixel();
    checkOutput("band_sel_pat", {6'd0, pat_a}, 8'h03);
    i_req = 1'b0;
    applyStimulus(1'b1, 10'h1A5, 10'h00C);
    checkOutput("band_c_R", r_a, 8'h00);
    checkOutput("band_c_G", g_a, 8'h00);
    checkOutput("band_c_B", b_a, 8'hA5);
    applyStimulus(1'b1, 10'h1A5, 10'h008);
    checkOutput("band_8_R", r_a, 8'hA5);
    checkOutput("band_8_G", g_a, 8'hA5);
    checkOutput("band_8_B", b_a, 8'h00);
    applyStimulus(1'b1, 10'h1A5, 10'h040);
    checkOutput("band_none_R", r_a, 8'h00);
    applyStimulus(1'b0, 10'h1A5, 10'h00C);
    checkOutput("band_blank_R", r_a, 8'h00);
    checkOutput("band_blank_B", b_a, 8'h00);
    checkOutput("band_blank_de", {7'd0, de_a}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
